// File: rtl/mdu_dispatch.sv
// mdu_dispatch: E-stage initiator for the multiply/divide unit handshake.
// Launches long ops with a one-cycle start pulse, passes short ops through, and stalls D while busy.
module mdu_dispatch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        stall_d,
    output logic        mdu_start,
    output logic [4:0]  mdu_op,
    output logic [31:0] mdu_d1,
    output logic [31:0] mdu_d2,
    input  logic        mdu_busy,
    output logic        err_timeout
);
    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MTLO  = 5'd8;
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q;
    logic          start_q;
    logic          err_q;
    logic [4:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [CW-1:0] cnt_q;
    logic          is_long;
    logic          is_short;

    assign is_long     = req_op >= OP_MULT && req_op <= OP_DIVU;
    assign is_short    = req_op >= OP_MFHI && req_op <= OP_MTLO;
    assign req_ready   = state_q == IDLE && !mdu_busy;
    assign stall_d     = req_valid && !req_ready;
    assign mdu_start   = start_q;
    assign err_timeout = err_q;
    // Short ops bypass the holding registers so HI/LO moves complete in the accept cycle.
    assign mdu_op = start_q ? op_q : (req_valid && req_ready && is_short) ? req_op : OP_NONE;
    assign mdu_d1 = state_q == IDLE ? req_a : a_q;
    assign mdu_d2 = state_q == IDLE ? req_b : b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req_valid && req_ready && is_long) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    start_q <= 1'b0;
                end
                WAIT: begin
                    // Watchdog only flags; the FSM keeps waiting for busy to fall.
                    if (cnt_q <= CW'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(TIMEOUT)) err_q <= 1'b1;
                    if (!mdu_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
